// File: rtl/gc_refresh_rotation_ctrl.sv
// ============================================================================
// Module   : gc_refresh_rotation_ctrl
// Brief    : Steers user access to the active gain-cell bank and rotates the
//            active bank through a three-bank refresh ring via sweep copies.
// Revision : 1.0
// ============================================================================
`default_nettype none

module gc_refresh_rotation_ctrl #(
    parameter int DATA_W       = 64,
    parameter int ADDR_W       = 7,
    parameter int DEPTH        = 128,
    parameter int REF_INTERVAL = 2000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  user_we,
    input  logic                  user_re,
    input  logic [ADDR_W-1:0]     user_waddr,
    input  logic [ADDR_W-1:0]     user_raddr,
    input  logic [DATA_W-1:0]     user_wdata,
    input  logic                  ref_req,
    input  logic [3*DATA_W-1:0]   bank_rd,
    input  logic [2:0]            bank_ref_done,
    output logic [2:0]            u_we,
    output logic [2:0]            u_re,
    output logic [2:0]            ref_en,
    output logic [2:0]            start_sr,
    output logic [ADDR_W-1:0]     u_waddr,
    output logic [ADDR_W-1:0]     u_raddr,
    output logic [DATA_W-1:0]     user_rdata,
    output logic                  user_rvalid,
    output logic [1:0]            active_bank,
    output logic                  ref_busy,
    output logic                  ref_err
);

    localparam int c_icnt_w = $clog2(REF_INTERVAL + 1);
    localparam int c_scnt_w = ADDR_W + 1;

    localparam logic [c_icnt_w-1:0] c_icnt_last = c_icnt_w'(REF_INTERVAL - 1);
    localparam logic [c_scnt_w-1:0] c_scnt_last = c_scnt_w'(DEPTH);

    localparam logic [1:0] c_idle   = 2'd0;
    localparam logic [1:0] c_start  = 2'd1;
    localparam logic [1:0] c_sweep  = 2'd2;
    localparam logic [1:0] c_rotate = 2'd3;

    logic [1:0]          r_state;
    logic [1:0]          r_active;
    logic [c_icnt_w-1:0] r_icnt;
    logic [c_scnt_w-1:0] r_sweep_cnt;
    logic                r_seen;
    logic                r_err;

    logic                r_rd_v1;
    logic [1:0]          r_rd_sel1;
    logic                r_rd_v2;
    logic [1:0]          r_rd_sel2;

    logic [1:0]          w_dst;
    logic [2:0]          w_src_oh;
    logic [2:0]          w_dst_oh;
    logic                w_done_dst;
    logic [1:0]          w_rd_sel;
    logic [DATA_W-1:0]   w_bank_rd [3];
    logic [DATA_W-1:0]   w_rd_mux;

    // ------------------------------------------------------------------
    // Ring arithmetic
    // ------------------------------------------------------------------
    assign w_dst      = (r_active == 2'd2) ? 2'd0 : r_active + 2'd1;
    assign w_src_oh   = 3'b001 << r_active;
    assign w_dst_oh   = 3'b001 << w_dst;
    assign w_done_dst = |(bank_ref_done & w_dst_oh);

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_rd_slice
            assign w_bank_rd[gi] = bank_rd[gi*DATA_W +: DATA_W];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Refresh sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_idle;
            r_active    <= 2'd0;
            r_icnt      <= '0;
            r_sweep_cnt <= '0;
            r_seen      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                c_idle: begin
                    r_seen <= 1'b0;
                    r_icnt <= r_icnt + 1'b1;
                    if ((r_icnt == c_icnt_last) || ref_req) begin
                        r_state <= c_start;
                    end
                end
                c_start: begin
                    r_sweep_cnt <= '0;
                    r_state     <= c_sweep;
                    if (w_done_dst) begin
                        r_seen <= 1'b1;
                    end
                end
                c_sweep: begin
                    if (w_done_dst) begin
                        r_seen <= 1'b1;
                    end
                    // Count saturates at DEPTH; that final cycle ends the sweep.
                    if (r_sweep_cnt == c_scnt_last) begin
                        r_state <= c_rotate;
                    end else begin
                        r_sweep_cnt <= r_sweep_cnt + 1'b1;
                    end
                end
                c_rotate: begin
                    r_active <= w_dst;
                    r_icnt   <= '0;
                    if (!r_seen) begin
                        r_err <= 1'b1;
                    end
                    r_state <= c_idle;
                end
                default: begin
                    r_state <= c_idle;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Read select: words below the sweep count already live in dst
    // ------------------------------------------------------------------
    always_comb begin
        w_rd_sel = r_active;
        if ((r_state == c_sweep) && ({1'b0, user_raddr} < r_sweep_cnt)) begin
            w_rd_sel = w_dst;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_v1   <= 1'b0;
            r_rd_sel1 <= 2'd0;
            r_rd_v2   <= 1'b0;
            r_rd_sel2 <= 2'd0;
        end else begin
            r_rd_v1   <= user_re;
            r_rd_sel1 <= w_rd_sel;
            r_rd_v2   <= r_rd_v1;
            r_rd_sel2 <= r_rd_sel1;
        end
    end

    always_comb begin
        case (r_rd_sel2)
            2'd0:    w_rd_mux = w_bank_rd[0];
            2'd1:    w_rd_mux = w_bank_rd[1];
            default: w_rd_mux = w_bank_rd[2];
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign u_we        = user_we ? w_src_oh : 3'b000;
    assign u_re        = user_re ? w_src_oh : 3'b000;
    assign start_sr    = (r_state == c_start) ? w_src_oh : 3'b000;
    assign ref_en      = ((r_state == c_start) || (r_state == c_sweep)) ? w_src_oh : 3'b000;
    assign u_waddr     = user_waddr;
    assign u_raddr     = user_raddr;
    assign user_rvalid = r_rd_v2;
    assign user_rdata  = r_rd_v2 ? w_rd_mux : '0;
    assign active_bank = r_active;
    assign ref_busy    = (r_state != c_idle);
    assign ref_err     = r_err;

    // Write data goes straight to the banks' u_data_in and is not used here.
    logic w_unused_wdata;
    assign w_unused_wdata = ^user_wdata;

endmodule

`default_nettype wire

// File: tb/tb_gc_refresh_rotation_ctrl.sv
// ============================================================================
// Module   : tb_gc_refresh_rotation_ctrl
// Brief    : Directed and randomized checks of the refresh rotation controller
//            against a cycle-count based behavioural model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_gc_refresh_rotation_ctrl;

    localparam int DATA_W       = 64;
    localparam int ADDR_W       = 7;
    localparam int DEPTH        = 128;
    localparam int REF_INTERVAL = 200;

    logic                clk = 1'b0;
    logic                rst;
    logic                user_we;
    logic                user_re;
    logic [ADDR_W-1:0]   user_waddr;
    logic [ADDR_W-1:0]   user_raddr;
    logic [DATA_W-1:0]   user_wdata;
    logic                ref_req;
    logic [3*DATA_W-1:0] bank_rd;
    logic [2:0]          bank_ref_done;
    logic [2:0]          u_we;
    logic [2:0]          u_re;
    logic [2:0]          ref_en;
    logic [2:0]          start_sr;
    logic [ADDR_W-1:0]   u_waddr;
    logic [ADDR_W-1:0]   u_raddr;
    logic [DATA_W-1:0]   user_rdata;
    logic                user_rvalid;
    logic [1:0]          active_bank;
    logic                ref_busy;
    logic                ref_err;

    always #5 clk = ~clk;

    gc_refresh_rotation_ctrl #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .REF_INTERVAL(REF_INTERVAL)
    ) dut (
        .clk(clk), .rst(rst),
        .user_we(user_we), .user_re(user_re),
        .user_waddr(user_waddr), .user_raddr(user_raddr), .user_wdata(user_wdata),
        .ref_req(ref_req), .bank_rd(bank_rd), .bank_ref_done(bank_ref_done),
        .u_we(u_we), .u_re(u_re), .ref_en(ref_en), .start_sr(start_sr),
        .u_waddr(u_waddr), .u_raddr(u_raddr),
        .user_rdata(user_rdata), .user_rvalid(user_rvalid),
        .active_bank(active_bank), .ref_busy(ref_busy), .ref_err(ref_err)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: m_t counts cycles since a refresh launch
    // (-1 idle, 0 launch cycle, 1..DEPTH+1 copying, DEPTH+2 pointer move).
    // ------------------------------------------------------------------
    int m_a, m_t, m_icnt;
    bit m_seen, m_err;
    bit p1v, p2v;
    int p1s, p2s;

    function automatic int dst_of(input int a);
        return (a + 1) % 3;
    endfunction

    task automatic model_reset();
        m_a = 0; m_t = -1; m_icnt = 0; m_seen = 0; m_err = 0;
        p1v = 0; p2v = 0; p1s = 0; p2s = 0;
    endtask

    task automatic model_step();
        int d;
        int sel;
        d   = dst_of(m_a);
        sel = m_a;
        if (m_t >= 1 && m_t <= DEPTH + 1 && int'(user_raddr) < m_t - 1) sel = d;
        p2v = p1v; p2s = p1s;
        p1v = user_re; p1s = sel;
        if (m_t < 0) begin
            if (m_icnt == REF_INTERVAL - 1 || ref_req) begin
                m_t = 0; m_seen = 0;
            end else begin
                m_icnt++;
            end
        end else if (m_t <= DEPTH + 1) begin
            if (bank_ref_done[d]) m_seen = 1;
            m_t++;
        end else begin
            if (!m_seen) m_err = 1;
            m_a = d; m_t = -1; m_icnt = 0;
        end
    endtask

    task automatic model_compare();
        logic [2:0]        oh;
        logic [63:0]       exp_rd;
        oh     = 3'b001 << m_a;
        exp_rd = p2v ? bank_rd[p2s*DATA_W +: DATA_W] : 64'd0;
        check("u_we",        u_we,        user_we ? oh : 3'b000);
        check("u_re",        u_re,        user_re ? oh : 3'b000);
        check("start_sr",    start_sr,    (m_t == 0) ? oh : 3'b000);
        check("ref_en",      ref_en,      (m_t >= 0 && m_t <= DEPTH + 1) ? oh : 3'b000);
        check("active_bank", active_bank, m_a);
        check("ref_busy",    ref_busy,    m_t >= 0);
        check("ref_err",     ref_err,     m_err);
        check("user_rvalid", user_rvalid, p2v);
        check("user_rdata",  user_rdata,  exp_rd);
        check("u_waddr",     u_waddr,     user_waddr);
        check("u_raddr",     u_raddr,     user_raddr);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rst) model_reset();
            model_compare();
            @(posedge clk);
            if (rst) model_reset();
            else     model_step();
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic pulse_req();
        @(negedge clk); ref_req = 1'b1;
        @(negedge clk); ref_req = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        #1;
        while (ref_busy && k < 400) begin
            @(negedge clk); #1; k++;
        end
        check(name, ref_busy, 1'b0);
    endtask

    initial begin
        int k;
        rst = 1'b1; user_we = 1'b0; user_re = 1'b0;
        user_waddr = '0; user_raddr = '0; user_wdata = '0; ref_req = 1'b0;
        bank_rd = {64'd3000, 64'd2000, 64'd1000};
        bank_ref_done = 3'b111;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_active_bank", active_bank, 2'd0);
        check("reset_ref_busy", ref_busy, 1'b0);

        // Interval-driven first refresh and its enable window length
        k = 0;
        while (start_sr == 3'b000 && k < 400) begin
            @(negedge clk); #1; k++;
        end
        check("first_start_cycle", k, 200);
        check("first_start_sr", start_sr, 3'b001);
        k = 0;
        while (ref_en != 3'b000 && k < 400) begin
            k++; @(negedge clk); #1;
        end
        check("ref_en_high_cycles", k, 130);
        check("rotate_busy", ref_busy, 1'b1);
        @(negedge clk); #1;
        check("active_after_sweep1", active_bank, 2'd1);
        check("idle_after_sweep1", ref_busy, 1'b0);

        // Reads at sweep count 50 during sweep 1->2
        pulse_req();
        repeat (51) @(negedge clk);
        user_re = 1'b1; user_raddr = 7'd20;
        @(negedge clk); user_raddr = 7'd120;
        @(negedge clk); user_re = 1'b0; #1;
        check("copied_read_valid", user_rvalid, 1'b1);
        check("copied_read_dst", user_rdata, 64'd3000);
        @(negedge clk); #1;
        check("uncopied_read_src", user_rdata, 64'd2000);
        wait_idle("wait_idle_sweep2");
        check("active_after_sweep2", active_bank, 2'd2);
        check("no_err_yet", ref_err, 1'b0);

        // Missing ref_done flags an error, and the pointer wraps 2->0
        bank_ref_done = 3'b000;
        pulse_req();
        wait_idle("wait_idle_err_sweep");
        check("err_set", ref_err, 1'b1);
        check("wrap_to_0", active_bank, 2'd0);
        bank_ref_done = 3'b111;
        pulse_req();
        wait_idle("wait_idle_sweep4");
        check("err_sticky", ref_err, 1'b1);
        check("active_bank_1", active_bank, 2'd1);

        // Reset in the middle of a sweep
        pulse_req();
        repeat (61) @(negedge clk);
        rst = 1'b1; #1;
        check("midreset_active", active_bank, 2'd0);
        check("midreset_err", ref_err, 1'b0);
        check("midreset_ref_en", ref_en, 3'b000);
        check("midreset_busy", ref_busy, 1'b0);
        @(negedge clk); rst = 1'b0;

        // Randomized traffic
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            user_we    = $urandom_range(0, 1) == 1;
            user_re    = $urandom_range(0, 1) == 1;
            user_waddr = ADDR_W'($urandom);
            user_raddr = ADDR_W'($urandom);
            user_wdata = {$urandom, $urandom};
            bank_rd    = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            ref_req    = $urandom_range(0, 299) == 0;
            for (int b = 0; b < 3; b++) bank_ref_done[b] = $urandom_range(0, 149) == 0;
            if (rst) rst = 1'b0;
            else if ($urandom_range(0, 3999) == 0) rst = 1'b1;
        end
        @(negedge clk);
        #3;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
